// File: rtl/beu_clmul_arbiter.sv
// beu_clmul_arbiter
//   Shares one multi-cycle carry-less multiply engine between two execute
//   lanes. Requests are arbitrated round-robin. The winning operation is held
//   on the engine inputs until the engine finishes, the watchdog expires or the
//   owner lane flushes. The captured result is then returned to the owner over
//   a valid/ready handshake.
//
// Ports (lane 1 occupies the upper slice of every packed per-lane bus)
//   s_clk_i, s_reset_i     clock, synchronous active-high reset
//   s_req_val_i[1:0]       request valid per lane
//   s_req_op_i[3:0]        2-bit op per lane: 0 CLMUL, 1 CLMULH, 2 CLMULR, 3 illegal
//   s_req_op1_i[63:0]      32-bit first operand per lane
//   s_req_op2_i[63:0]      32-bit second operand per lane
//   s_req_rdy_o[1:0]       request accepted (one-hot or zero, IDLE only)
//   s_flush_i[1:0]         per-lane flush
//   s_rsp_val_o[1:0]       response valid (one-hot or zero, DONE only)
//   s_rsp_rdy_i[1:0]       response ready per lane
//   s_rsp_res_o[31:0]      response result (zero outside DONE)
//   s_rsp_err_o            response error: illegal op or watchdog timeout
//   s_eng_compute_o        engine compute enable, high for the whole RUN state
//   s_eng_fun_o[1:0]       engine function, encoded like the request op
//   s_eng_op1_o/op2_o      registered engine operands
//   s_eng_flush_o          one-cycle engine flush pulse
//   s_eng_finished_i       engine finished
//   s_eng_result_i[31:0]   engine result
module beu_clmul_arbiter #(
   parameter int TIMEOUT = 40
) (
   input  logic        s_clk_i,
   input  logic        s_reset_i,
   input  logic [1:0]  s_req_val_i,
   input  logic [3:0]  s_req_op_i,
   input  logic [63:0] s_req_op1_i,
   input  logic [63:0] s_req_op2_i,
   output logic [1:0]  s_req_rdy_o,
   input  logic [1:0]  s_flush_i,
   output logic [1:0]  s_rsp_val_o,
   input  logic [1:0]  s_rsp_rdy_i,
   output logic [31:0] s_rsp_res_o,
   output logic        s_rsp_err_o,
   output logic        s_eng_compute_o,
   output logic [1:0]  s_eng_fun_o,
   output logic [31:0] s_eng_op1_o,
   output logic [31:0] s_eng_op2_o,
   output logic        s_eng_flush_o,
   input  logic        s_eng_finished_i,
   input  logic [31:0] s_eng_result_i
);

   localparam int         WD_W       = $clog2(TIMEOUT);
   localparam logic [1:0] OP_ILLEGAL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic              ptr_q;        // lane granted last
   logic              owner_q;
   logic [1:0]        fun_q;
   logic [31:0]       op1_q;
   logic [31:0]       op2_q;
   logic [31:0]       res_q;
   logic              err_q;
   logic [WD_W-1:0]   wd_q;
   logic              eng_flush_q;
   logic              rst_flush_q;  // reset hit an operation in RUN

   logic [1:0]        elig;
   logic [1:0]        grant;
   logic              winner;
   logic [1:0]        win_op;
   logic [31:0]       win_op1;
   logic [31:0]       win_op2;

   // Round-robin: on a tie the lane not granted last wins.
   always_comb begin
      elig  = s_req_val_i & ~s_flush_i;
      grant = 2'b00;
      if (state_q == ST_IDLE && !s_reset_i) begin
         if (elig == 2'b11) grant = ptr_q ? 2'b01 : 2'b10;
         else               grant = elig;
      end
   end

   assign winner  = grant[1];
   assign win_op  = winner ? s_req_op_i[3:2]   : s_req_op_i[1:0];
   assign win_op1 = winner ? s_req_op1_i[63:32] : s_req_op1_i[31:0];
   assign win_op2 = winner ? s_req_op2_i[63:32] : s_req_op2_i[31:0];

   assign s_req_rdy_o     = grant;
   assign s_rsp_val_o     = (state_q == ST_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign s_rsp_res_o     = (state_q == ST_DONE) ? res_q : '0;
   assign s_rsp_err_o     = (state_q == ST_DONE) && err_q;
   assign s_eng_compute_o = (state_q == ST_RUN);
   assign s_eng_fun_o     = fun_q;
   assign s_eng_op1_o     = op1_q;
   assign s_eng_op2_o     = op2_q;
   assign s_eng_flush_o   = eng_flush_q;

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         state_q     <= ST_IDLE;
         ptr_q       <= 1'b1;
         owner_q     <= 1'b0;
         fun_q       <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         res_q       <= '0;
         err_q       <= 1'b0;
         wd_q        <= '0;
         eng_flush_q <= 1'b0;
         // Sticky across a multi-cycle reset so the engine counter gets
         // cleared once reset releases.
         rst_flush_q <= rst_flush_q | (state_q == ST_RUN);
      end else begin
         eng_flush_q <= rst_flush_q;
         rst_flush_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant != 2'b00) begin
                  owner_q <= winner;
                  ptr_q   <= winner;
                  fun_q   <= win_op;
                  op1_q   <= win_op1;
                  op2_q   <= win_op2;
                  wd_q    <= '0;
                  if (win_op == OP_ILLEGAL) begin
                     res_q   <= '0;
                     err_q   <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               // Owner flush beats finished, finished beats the watchdog.
               if (s_flush_i[owner_q]) begin
                  eng_flush_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else if (s_eng_finished_i) begin
                  res_q   <= s_eng_result_i;
                  err_q   <= 1'b0;
                  state_q <= ST_DONE;
               end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                  eng_flush_q <= 1'b1;
                  res_q       <= '0;
                  err_q       <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            ST_DONE: begin
               if (s_flush_i[owner_q] || s_rsp_rdy_i[owner_q]) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_beu_clmul_arbiter.sv
// Bench for beu_clmul_arbiter: a behavioural carry-less multiply engine
// model, a scoreboard of expected responses per lane, directed scenarios and
// a randomized traffic phase.
module tb_beu_clmul_arbiter;
   localparam int TIMEOUT = 40;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  req_val;
   logic [3:0]  req_op;
   logic [63:0] req_op1, req_op2;
   logic [1:0]  req_rdy;
   logic [1:0]  flush;
   logic [1:0]  rsp_val;
   logic [1:0]  rsp_rdy;
   logic [31:0] rsp_res;
   logic        rsp_err;
   logic        eng_compute;
   logic [1:0]  eng_fun;
   logic [31:0] eng_op1, eng_op2;
   logic        eng_flush;
   logic        eng_finished;
   logic [31:0] eng_result;

   beu_clmul_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .s_clk_i(clk), .s_reset_i(rst),
      .s_req_val_i(req_val), .s_req_op_i(req_op),
      .s_req_op1_i(req_op1), .s_req_op2_i(req_op2),
      .s_req_rdy_o(req_rdy), .s_flush_i(flush),
      .s_rsp_val_o(rsp_val), .s_rsp_rdy_i(rsp_rdy),
      .s_rsp_res_o(rsp_res), .s_rsp_err_o(rsp_err),
      .s_eng_compute_o(eng_compute), .s_eng_fun_o(eng_fun),
      .s_eng_op1_o(eng_op1), .s_eng_op2_o(eng_op2),
      .s_eng_flush_o(eng_flush), .s_eng_finished_i(eng_finished),
      .s_eng_result_i(eng_result)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [32:0] exp_q0[$];
   logic [32:0] exp_q1[$];
   int          compute_cycles = 0;

   // Full 64-bit carry-less product; the three ops are windows into it.
   function automatic logic [63:0] clmul64(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = '0;
      for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'b0, a} << i);
      return p;
   endfunction

   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = clmul64(a, b);
      case (op)
         2'd0:    return p[31:0];
         2'd1:    return p[63:32];
         2'd2:    return p[62:31];
         default: return 32'd0;
      endcase
   endfunction

   // Engine latency in compute cycles: 1 for a zero operand, up to 33.
   function automatic int eng_lat(input logic [31:0] a, input logic [31:0] b);
      if (a == 0 || b == 0) return 1;
      return 1 + int'((a ^ b ^ (a >> 7)) % 32'd33);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Engine model
   int          eng_cnt = 0;
   logic        eng_hang = 1'b0;
   logic [31:0] garbage = 32'hdead_beef;
   always @(posedge clk) begin
      if (rst || !eng_compute || eng_flush) eng_cnt <= 0;
      else                                  eng_cnt <= eng_cnt + 1;
      garbage <= $urandom;
   end
   assign eng_finished = eng_compute && !eng_hang && (eng_cnt == eng_lat(eng_op1, eng_op2));
   assign eng_result   = eng_finished ? ref_res(eng_fun, eng_op1, eng_op2) : garbage;

   // Scoreboard: push on request handshake, pop and compare on response handshake.
   initial begin
      logic [1:0]  hold;
      logic [32:0] held0, held1, e;
      logic [1:0]  op;
      logic [31:0] a, b;
      hold = 2'b00; held0 = '0; held1 = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 2'b00;
         end else begin
            if (eng_compute) compute_cycles++;
            check("req_rdy_onehot0", 64'($countones(req_rdy) <= 1), 64'd1);
            check("rsp_val_onehot0", 64'($countones(rsp_val) <= 1), 64'd1);
            if (rsp_val == 2'b00) check("rsp_idle_zero", {31'b0, rsp_err, rsp_res}, 64'd0);
            if (hold[0]) check("rsp_stable_lane0", {30'b0, rsp_val[0], rsp_err, rsp_res}, {30'b0, 1'b1, held0});
            if (hold[1]) check("rsp_stable_lane1", {30'b0, rsp_val[1], rsp_err, rsp_res}, {30'b0, 1'b1, held1});
            for (int i = 0; i < 2; i++) begin
               if (req_val[i] && req_rdy[i]) begin
                  op = req_op[2*i +: 2];
                  a  = req_op1[32*i +: 32];
                  b  = req_op2[32*i +: 32];
                  if (op == 2'd3 || eng_hang) e = {1'b1, 32'd0};
                  else                        e = {1'b0, ref_res(op, a, b)};
                  if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
               end
               if (rsp_val[i] && rsp_rdy[i] && !flush[i]) begin
                  if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                     n_cmp++; n_bad++;
                     $display("FAIL rsp_unexpected lane %0d: got res 0x%0h err %0d, expected no response", i, rsp_res, rsp_err);
                  end else begin
                     e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                     check(i == 0 ? "rsp_lane0" : "rsp_lane1", {31'b0, rsp_err, rsp_res}, {31'b0, e});
                  end
               end
            end
            hold  = rsp_val & ~rsp_rdy & ~flush;
            held0 = {rsp_err, rsp_res};
            held1 = {rsp_err, rsp_res};
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic req(input int lane, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (lane == 0) begin
         req_op[1:0] = op; req_op1[31:0] = a; req_op2[31:0] = b; req_val[0] = 1'b1;
      end else begin
         req_op[3:2] = op; req_op1[63:32] = a; req_op2[63:32] = b; req_val[1] = 1'b1;
      end
   endtask

   task automatic wait_grant(input int lane, output int gcyc, output logic [1:0] first_rdy);
      gcyc = -1; first_rdy = 2'b00;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (k == 0) first_rdy = req_rdy;
         if (req_rdy[lane]) begin gcyc = cyc; break; end
      end
      if (gcyc < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL grant_wait lane %0d: got no grant, expected one within 200 cycles", lane);
      end
      tick();
      req_val[lane] = 1'b0;
   endtask

   task automatic wait_rsp(input int lane, output int rcyc, output logic flush_at);
      rcyc = -1; flush_at = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (rsp_val[lane]) begin rcyc = cyc; flush_at = eng_flush; break; end
      end
      if (rcyc < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL rsp_wait lane %0d: got no response, expected one within 200 cycles", lane);
      end
      tick();
   endtask

   initial begin
      #900000;
      $display("FAIL global_watchdog: got no end of test, expected finish before 900us");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int          g, g1, r, r0, issued;
      logic [1:0]  fr, hs;
      logic        ff;
      logic [31:0] a1, b1;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      bit          done;

      rst = 1'b1; req_val = '0; req_op = '0; req_op1 = '0; req_op2 = '0;
      flush = '0; rsp_rdy = '0;
      tick();
      req_val = 2'b11;
      repeat (2) tick();
      @(negedge clk);
      check("reset_req_rdy", req_rdy, 2'b00);
      check("reset_rsp_val", rsp_val, 2'b00);
      check("reset_rsp_res", rsp_res, 32'd0);
      check("reset_rsp_err", rsp_err, 1'b0);
      check("reset_compute", eng_compute, 1'b0);
      check("reset_eng_flush", eng_flush, 1'b0);
      check("reset_eng_ops", {eng_op1, eng_op2}, 64'd0);
      check("reset_eng_fun", eng_fun, 2'd0);
      tick();
      req_val = 2'b00; rst = 1'b0;
      repeat (2) tick();

      // Tie from reset, then round-robin
      rsp_rdy = 2'b11;
      req(0, 2'd0, 32'h3, 32'h5);
      req(1, 2'd1, 32'h8000_0000, 32'h8000_0000);
      wait_grant(0, g, fr);
      check("tie_first_grant", fr, 2'b01);
      wait_rsp(0, r0, ff);
      check("clmul_latency", r0 - g, 2 + eng_lat(32'h3, 32'h5));
      wait_grant(1, g1, fr);
      check("rr_grant_after_handshake", g1, r0 + 1);
      wait_rsp(1, r, ff);
      req(0, 2'd2, 32'h8000_0000, 32'h8000_0000);
      req(1, 2'd2, 32'h8000_0000, 32'h8000_0000);
      wait_grant(0, g, fr);
      check("second_tie_grant", fr, 2'b01);
      wait_rsp(0, r, ff);
      wait_grant(1, g, fr);
      wait_rsp(1, r, ff);

      // Zero operand and illegal op
      req(0, 2'd0, 32'd0, $urandom);
      wait_grant(0, g, fr);
      wait_rsp(0, r, ff);
      check("zero_op_latency", r - g, 3);
      g1 = compute_cycles;
      req(1, 2'd3, $urandom, $urandom);
      wait_grant(1, g, fr);
      wait_rsp(1, r, ff);
      check("illegal_latency", r - g, 1);
      check("illegal_no_compute", compute_cycles - g1, 0);

      // Owner flush in RUN, then non-owner flush
      a1 = 32'h0000_00F0; b1 = 32'h0000_0F0F;
      req(0, 2'd0, 32'h1, 32'h21);
      wait_grant(0, g, fr);
      req(1, 2'd1, a1, b1);
      repeat (4) tick();
      flush = 2'b01;
      void'(exp_q0.pop_back());
      tick();
      flush = 2'b00;
      @(negedge clk);
      check("flush_eng_pulse", eng_flush, 1'b1);
      check("flush_other_granted", req_rdy, 2'b10);
      g1 = cyc;
      tick();
      req_val[1] = 1'b0;
      @(negedge clk);
      check("flush_pulse_single", eng_flush, 1'b0);
      tick();
      flush = 2'b01;
      tick();
      flush = 2'b00;
      wait_rsp(1, r, ff);
      check("nonowner_flush_latency", r - g1, 2 + eng_lat(a1, b1));

      // Watchdog timeout
      eng_hang = 1'b1;
      req(0, 2'd0, 32'h1234, 32'h5678);
      wait_grant(0, g, fr);
      wait_rsp(0, r, ff);
      check("timeout_latency", r - g, TIMEOUT + 1);
      check("timeout_eng_flush", ff, 1'b1);
      eng_hang = 1'b0;

      // Reset while in RUN
      req(0, 2'd0, 32'h1, 32'h21);
      wait_grant(0, g, fr);
      tick();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      exp_q0.delete();
      @(negedge clk);
      check("rst_run_compute", eng_compute, 1'b0);
      check("rst_run_flush_during", eng_flush, 1'b0);
      tick();
      @(negedge clk);
      check("rst_run_flush_after", eng_flush, 1'b1);
      tick();
      @(negedge clk);
      check("rst_run_flush_single", eng_flush, 1'b0);
      tick();

      // Randomized traffic with response backpressure
      issued = 0; done = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         if (issued >= 120 && req_val == 2'b00 && exp_q0.size() == 0 && exp_q1.size() == 0) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
         hs = req_val & req_rdy;
         tick();
         for (int i = 0; i < 2; i++) begin
            if (hs[i]) req_val[i] = 1'b0;
            if (!req_val[i] && issued < 120 && $urandom_range(0, 3) == 0) begin
               rop = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
               ra  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
               rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
               req(i, rop, ra, rb);
               issued++;
            end
         end
         rsp_rdy = {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7)};
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL random_drain: got %0d+%0d pending, expected all responses within budget",
                  exp_q0.size(), exp_q1.size());
      end
      rsp_rdy = 2'b11;
      repeat (3) tick();
      check("queues_empty", exp_q0.size() + exp_q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
